apb2axi_write_burst_builder: RTL and testbench

- Second-generation write builder: accepts write commands and issues multi-beat AXI INCR bursts with independent AW and W channels.
- Streams beats from a separate write-data FIFO and tracks up to MAX_OUTSTANDING bursts awaiting B.
- Forwards each B response as a completion to the directory.
- Sits between the write command FIFO / write-data FIFO and the AXI master port.

---
 rtl/apb2axi_write_burst_builder.sv | 214 +++++++++++++++++++++
 tb/tb_apb2axi_write_burst_builder.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb2axi_write_burst_builder.sv
// Write burst builder: turns write commands into AXI INCR bursts on independent AW/W
// channels, tracks bursts awaiting B and forwards each B response as a completion.
module apb2axi_write_burst_builder #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int ID_W            = 4,
    parameter int LEN_W           = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STRB_W          = DATA_W / 8,
    parameter int OCNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic              i_aclk,
    input  logic              i_aresetn,
    input  logic              i_cmd_vld,
    output logic              o_cmd_rdy,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic [2:0]        i_cmd_size,
    input  logic [ID_W-1:0]   i_cmd_id,
    input  logic              i_wd_vld,
    output logic              o_wd_rdy,
    input  logic [DATA_W-1:0] i_wd_data,
    input  logic [STRB_W-1:0] i_wd_strb,
    output logic [ID_W-1:0]   o_awid,
    output logic [ADDR_W-1:0] o_awaddr,
    output logic [LEN_W-1:0]  o_awlen,
    output logic [2:0]        o_awsize,
    output logic [1:0]        o_awburst,
    output logic [3:0]        o_awcache,
    output logic [2:0]        o_awprot,
    output logic              o_awvalid,
    input  logic              i_awready,
    output logic [DATA_W-1:0] o_wdata,
    output logic [STRB_W-1:0] o_wstrb,
    output logic              o_wlast,
    output logic              o_wvalid,
    input  logic              i_wready,
    input  logic [ID_W-1:0]   i_bid,
    input  logic [1:0]        i_bresp,
    input  logic              i_bvalid,
    output logic              o_bready,
    output logic              o_cpl_vld,
    output logic [ID_W-1:0]   o_cpl_id,
    output logic [1:0]        o_cpl_resp,
    output logic [OCNT_W-1:0] o_outstanding
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);

    typedef enum logic {W_IDLE, W_BURST} wstate_t;

    wstate_t           r_wstate;
    wstate_t           w_wstate_nxt;
    logic              r_awvalid;
    logic [ID_W-1:0]   r_awid;
    logic [ADDR_W-1:0] r_awaddr;
    logic [LEN_W-1:0]  r_awlen;
    logic [2:0]        r_awsize;
    logic [OCNT_W-1:0] r_outstanding;
    logic [LEN_W-1:0]  r_lenq [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [OCNT_W-1:0] r_qcnt;
    logic [LEN_W-1:0]  r_beat;
    logic [LEN_W-1:0]  r_cur_len;
    logic              r_cpl_vld;
    logic [ID_W-1:0]   r_cpl_id;
    logic [1:0]        r_cpl_resp;

    logic w_cmd_acc;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_w_done;
    logic w_b_hs;
    logic w_q_nonempty;

    assign o_cmd_rdy    = !r_awvalid && (r_outstanding < OCNT_W'(MAX_OUTSTANDING));
    assign o_bready     = (r_outstanding != '0);
    assign w_cmd_acc    = i_cmd_vld && o_cmd_rdy;
    assign w_aw_hs      = r_awvalid && i_awready;
    assign w_w_hs       = o_wvalid && i_wready;
    assign w_w_done     = w_w_hs && o_wlast;
    assign w_b_hs       = i_bvalid && o_bready;
    assign w_q_nonempty = (r_qcnt != '0);

    assign o_awid        = r_awid;
    assign o_awaddr      = r_awaddr;
    assign o_awlen       = r_awlen;
    assign o_awsize      = r_awsize;
    assign o_awburst     = 2'b01;
    assign o_awcache     = 4'b0011;
    assign o_awprot      = 3'b000;
    assign o_awvalid     = r_awvalid;
    assign o_wdata       = i_wd_data;
    assign o_wstrb       = i_wd_strb;
    assign o_cpl_vld     = r_cpl_vld;
    assign o_cpl_id      = r_cpl_id;
    assign o_cpl_resp    = r_cpl_resp;
    assign o_outstanding = r_outstanding;

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_awvalid <= 1'b0;
            r_awid    <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
        end else if (w_cmd_acc) begin
            r_awvalid <= 1'b1;
            r_awid    <= i_cmd_id;
            r_awaddr  <= i_cmd_addr;
            r_awlen   <= i_cmd_len;
            r_awsize  <= i_cmd_size;
        end else if (w_aw_hs) begin
            r_awvalid <= 1'b0;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_outstanding <= '0;
        end else if (w_cmd_acc && !w_b_hs) begin
            r_outstanding <= r_outstanding + 1'b1;
        end else if (!w_cmd_acc && w_b_hs) begin
            r_outstanding <= r_outstanding - 1'b1;
        end
    end

    // Length queue storage needs no reset; only the pointers and count define occupancy.
    always_ff @(posedge i_aclk) begin
        if (w_cmd_acc) begin
            r_lenq[r_wptr] <= i_cmd_len;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_qcnt <= '0;
        end else begin
            if (w_cmd_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_w_done) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_cmd_acc && !w_w_done) begin
                r_qcnt <= r_qcnt + 1'b1;
            end else if (!w_cmd_acc && w_w_done) begin
                r_qcnt <= r_qcnt - 1'b1;
            end
        end
    end

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    // W data is a pure pass-through of the data FIFO while a burst is open.
    always_comb begin
        w_wstate_nxt = r_wstate;
        o_wvalid     = 1'b0;
        o_wd_rdy     = 1'b0;
        o_wlast      = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_q_nonempty) begin
                    w_wstate_nxt = W_BURST;
                end
            end
            W_BURST: begin
                o_wvalid = i_wd_vld;
                o_wd_rdy = i_wready;
                o_wlast  = (r_beat == r_cur_len);
                if (i_wd_vld && i_wready && (r_beat == r_cur_len)) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_beat    <= '0;
            r_cur_len <= '0;
        end else if (r_wstate == W_IDLE && w_q_nonempty) begin
            r_beat    <= '0;
            r_cur_len <= r_lenq[r_rptr];
        end else if (r_wstate == W_BURST && w_w_hs) begin
            r_beat <= r_beat + 1'b1;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_cpl_vld  <= 1'b0;
            r_cpl_id   <= '0;
            r_cpl_resp <= '0;
        end else begin
            r_cpl_vld <= w_b_hs;
            if (w_b_hs) begin
                r_cpl_id   <= i_bid;
                r_cpl_resp <= i_bresp;
            end
        end
    end

endmodule

// File: tb/tb_apb2axi_write_burst_builder.sv
// Scoreboard bench for apb2axi_write_burst_builder: random AXI slave and data FIFO,
// expected AW/W/completion traffic queued at command issue and checked by a monitor.
module tb_apb2axi_write_burst_builder;

    localparam int MAXO = 4;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [3:0]  id;
    } aw_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } beat_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    logic        aclk;
    logic        aresetn;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [3:0]  cmd_id;
    logic        wd_vld;
    logic        wd_rdy;
    logic [63:0] wd_data;
    logic [7:0]  wd_strb;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        cpl_vld;
    logic [3:0]  cpl_id;
    logic [1:0]  cpl_resp;
    logic [2:0]  outstanding;

    aw_t        expAw[$];
    beat_t      expW[$];
    beat_t      wdFifo[$];
    b_t         pendingB[$];
    b_t         expCpl[$];
    logic [3:0] awIds[$];

    int vectors     = 0;
    int miscompares = 0;
    int mOut        = 0;
    bit mAwPend     = 0;
    int wLastCnt    = 0;
    int wHsCount    = 0;
    bit wdPop       = 0;
    bit bPop        = 0;
    bit bEnable     = 1;
    bit awHold      = 0;
    bit strayB      = 0;

    apb2axi_write_burst_builder dut (
        .i_aclk        (aclk),
        .i_aresetn     (aresetn),
        .i_cmd_vld     (cmd_vld),
        .o_cmd_rdy     (cmd_rdy),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_len     (cmd_len),
        .i_cmd_size    (cmd_size),
        .i_cmd_id      (cmd_id),
        .i_wd_vld      (wd_vld),
        .o_wd_rdy      (wd_rdy),
        .i_wd_data     (wd_data),
        .i_wd_strb     (wd_strb),
        .o_awid        (awid),
        .o_awaddr      (awaddr),
        .o_awlen       (awlen),
        .o_awsize      (awsize),
        .o_awburst     (awburst),
        .o_awcache     (awcache),
        .o_awprot      (awprot),
        .o_awvalid     (awvalid),
        .i_awready     (awready),
        .o_wdata       (wdata),
        .o_wstrb       (wstrb),
        .o_wlast       (wlast),
        .o_wvalid      (wvalid),
        .i_wready      (wready),
        .i_bid         (bid),
        .i_bresp       (bresp),
        .i_bvalid      (bvalid),
        .o_bready      (bready),
        .o_cpl_vld     (cpl_vld),
        .o_cpl_id      (cpl_id),
        .o_cpl_resp    (cpl_resp),
        .o_outstanding (outstanding)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNote(input string name, input string what);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got %s expected none", name, what);
    endtask

    // Issue one command; expected AW and beats are queued at the negedge before acceptance.
    task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [3:0] id);
        aw_t   a;
        beat_t b;
        bit    ok;
        ok       = 1'b0;
        cmd_vld  = 1'b1;
        cmd_addr = addr;
        cmd_len  = len;
        cmd_size = size;
        cmd_id   = id;
        for (int c = 0; c < 3000; c++) begin
            @(negedge aclk);
            if (cmd_rdy) begin
                ok     = 1'b1;
                a.addr = addr;
                a.len  = len;
                a.size = size;
                a.id   = id;
                expAw.push_back(a);
                for (int i = 0; i <= int'(len); i++) begin
                    b.data = {$urandom, $urandom};
                    b.strb = 8'($urandom);
                    b.last = (i == int'(len));
                    expW.push_back(b);
                    wdFifo.push_back(b);
                end
                break;
            end
        end
        if (!ok) failNote("cmd_accept", "timeout");
        @(posedge aclk);
        #1;
        cmd_vld = 1'b0;
    endtask

    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge aclk);
            if (expAw.size() == 0 && expW.size() == 0 && pendingB.size() == 0 &&
                expCpl.size() == 0 && awIds.size() == 0 && mOut == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) failNote("drain", "timeout");
        #1;
    endtask

    // Random AXI slave and write-data FIFO.
    initial begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bid     = '0;
        bresp   = '0;
        wd_vld  = 1'b0;
        wd_data = '0;
        wd_strb = '0;
        forever begin
            @(posedge aclk);
            if (wdPop && wdFifo.size() > 0) void'(wdFifo.pop_front());
            if (bPop && pendingB.size() > 0) void'(pendingB.pop_front());
            #1;
            awready = awHold ? 1'b0 : ($urandom_range(0, 3) != 0);
            wready  = ($urandom_range(0, 3) != 0);
            if (wdFifo.size() > 0 && $urandom_range(0, 4) != 0) begin
                wd_vld  = 1'b1;
                wd_data = wdFifo[0].data;
                wd_strb = wdFifo[0].strb;
            end else begin
                wd_vld  = 1'b0;
                wd_data = {$urandom, $urandom};
                wd_strb = 8'($urandom);
            end
            if (strayB) begin
                bvalid = 1'b1;
                bid    = 4'd5;
                bresp  = 2'b11;
            end else if (bEnable && pendingB.size() > 0 && $urandom_range(0, 2) != 0) begin
                bvalid = 1'b1;
                bid    = pendingB[0].id;
                bresp  = pendingB[0].resp;
            end else begin
                bvalid = 1'b0;
            end
        end
    end

    // Monitor: compare presented outputs, then record the handshakes of the coming edge.
    always @(negedge aclk) begin
        b_t nb;
        if (!aresetn) begin
            wdPop = 1'b0;
            bPop  = 1'b0;
        end else begin
            checkOutput("outstanding", 64'(outstanding), 64'(mOut));
            checkOutput("cmd_rdy", 64'(cmd_rdy), 64'(!mAwPend && mOut < MAXO));
            checkOutput("bready", 64'(bready), 64'(mOut != 0));
            checkOutput("awvalid", 64'(awvalid), 64'(mAwPend));
            if (awvalid) begin
                if (expAw.size() == 0) begin
                    failNote("aw_payload", "unexpected AW");
                end else begin
                    checkOutput("aw_payload", 64'({awaddr, awlen, awsize, awid}),
                                64'({expAw[0].addr, expAw[0].len, expAw[0].size, expAw[0].id}));
                    checkOutput("aw_fixed", 64'({awburst, awcache, awprot}),
                                64'({2'b01, 4'b0011, 3'b000}));
                    if (awready) begin
                        awIds.push_back(expAw[0].id);
                        void'(expAw.pop_front());
                        mAwPend = 1'b0;
                    end
                end
            end
            if (wvalid && wready) begin
                wHsCount++;
                if (expW.size() == 0) begin
                    failNote("w_beat", "unexpected W beat");
                end else begin
                    checkOutput("w_beat", {wdata[62:0], 1'b0} ^ 64'({wstrb, wlast}),
                                {expW[0].data[62:0], 1'b0} ^ 64'({expW[0].strb, expW[0].last}));
                    checkOutput("w_data", wdata, expW[0].data);
                    checkOutput("w_last", 64'({wstrb, wlast}), 64'({expW[0].strb, expW[0].last}));
                    if (expW[0].last) wLastCnt++;
                    void'(expW.pop_front());
                end
            end
            if (cpl_vld) begin
                if (expCpl.size() == 0) begin
                    failNote("cpl", "unexpected completion");
                end else begin
                    checkOutput("cpl", 64'({cpl_id, cpl_resp}), 64'({expCpl[0].id, expCpl[0].resp}));
                    void'(expCpl.pop_front());
                end
            end
            bPop = 1'b0;
            if (bvalid && bready) begin
                if (pendingB.size() == 0) begin
                    failNote("b_accept", "B accepted with nothing pending");
                end else begin
                    expCpl.push_back(pendingB[0]);
                    bPop = 1'b1;
                end
                mOut--;
            end
            if (cmd_vld && cmd_rdy) begin
                mOut++;
                mAwPend = 1'b1;
            end
            wdPop = wd_vld && wd_rdy;
            while (awIds.size() > 0 && wLastCnt > 0) begin
                nb.id   = awIds.pop_front();
                nb.resp = 2'($urandom_range(0, 3));
                pendingB.push_back(nb);
                wLastCnt--;
            end
        end
    end

    initial begin
        int base;
        bit seen;
        logic [7:0] len;
        aresetn  = 1'b0;
        cmd_vld  = 1'b0;
        cmd_addr = '0;
        cmd_len  = '0;
        cmd_size = '0;
        cmd_id   = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("rst_awvalid", 64'(awvalid), 64'd0);
        checkOutput("rst_wvalid", 64'({wvalid, wlast}), 64'd0);
        checkOutput("rst_cpl_vld", 64'(cpl_vld), 64'd0);
        checkOutput("rst_outstanding", 64'(outstanding), 64'd0);
        checkOutput("rst_aw_payload", 64'({awaddr, awlen, awsize, awid}), 64'd0);
        checkOutput("rst_ready", 64'({cmd_rdy, bready}), 64'b10);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        applyStimulus(32'h0000_1000, 8'd0, 3'd3, 4'd3);
        waitDrain();

        // AW withheld while the whole W burst drains.
        awHold = 1'b1;
        base   = wHsCount;
        applyStimulus(32'h0000_2000, 8'd3, 3'd3, 4'd9);
        seen = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(posedge aclk);
            if (wHsCount >= base + 4) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) failNote("w_before_aw", "timeout");
        @(negedge aclk);
        checkOutput("aw_held_valid", 64'(awvalid), 64'd1);
        checkOutput("aw_held_addr", 64'(awaddr), 64'h2000);
        #1;
        awHold = 1'b0;
        waitDrain();

        // Fill to the outstanding limit with B withheld, then hold a fifth command.
        bEnable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(32'h0001_0000 + 32'(k * 64), 8'(k), 3'd3, 4'(k + 1));
        end
        fork
            applyStimulus(32'h0002_0000, 8'd1, 3'd3, 4'd7);
            begin
                repeat (15) @(negedge aclk);
                checkOutput("full_outstanding", 64'(outstanding), 64'd4);
                checkOutput("full_cmd_rdy", 64'(cmd_rdy), 64'd0);
                bEnable = 1'b1;
            end
        join
        waitDrain();

        for (int n = 0; n < 40; n++) begin
            if (n == 20) len = 8'd255;
            else if ($urandom_range(0, 9) < 7) len = 8'($urandom_range(0, 3));
            else len = 8'($urandom_range(4, 15));
            applyStimulus($urandom, len, 3'($urandom_range(0, 3)), 4'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge aclk);
            #1;
        end
        waitDrain();

        // A B presented with nothing outstanding must be ignored.
        strayB = 1'b1;
        repeat (5) @(posedge aclk);
        #1;
        strayB = 1'b0;
        repeat (4) @(posedge aclk);
        #1;

        // Reset in the middle of a four-beat burst.
        base = wHsCount;
        applyStimulus(32'h0000_3000, 8'd3, 3'd3, 4'd10);
        seen = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(posedge aclk);
            if (wHsCount >= base + 1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) failNote("mid_burst_beat", "timeout");
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        checkOutput("midrst_awvalid", 64'(awvalid), 64'd0);
        checkOutput("midrst_wvalid", 64'(wvalid), 64'd0);
        checkOutput("midrst_outstanding", 64'(outstanding), 64'd0);
        checkOutput("midrst_cpl_vld", 64'(cpl_vld), 64'd0);
        expAw.delete();
        expW.delete();
        wdFifo.delete();
        pendingB.delete();
        expCpl.delete();
        awIds.delete();
        mOut     = 0;
        mAwPend  = 1'b0;
        wLastCnt = 0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        applyStimulus(32'h0000_4000, 8'd3, 3'd3, 4'd11);
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
